game_ctrl_fsm: RTL

Parametrised game-flow controller for pong, the successor to the two-state start/play FSM. It owns both score counters and sequences the game through idle, serve countdown, rally, pause and game-over phases. Serve and game-over timing is counted in frame ticks. It supports a configurable target score, a win-by-margin (deuce) rule, a pause toggle and winner reporting. It sits between the input/collision logic (point and control pulses) and the ball/paddle/score-display logic.

---
 rtl/game_ctrl_fsm.sv | 106 ++++++++++
 1 files changed

// File: rtl/game_ctrl_fsm.sv
// game_ctrl_fsm: pong game-flow controller owning both scores and the
// idle/serve/play/pause/over sequencing, with target score and deuce rule.
module game_ctrl_fsm #(
   parameter int SCORE_W     = 4,
   parameter int MAX_SCORE   = 10,
   parameter int WIN_MARGIN  = 2,
   parameter int SERVE_TICKS = 60,
   parameter int OVER_TICKS  = 180
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               game_rst_i,
   input  logic               pause_i,
   input  logic               frame_tick_i,
   input  logic               p_point_i,
   input  logic               e_point_i,
   output logic [SCORE_W-1:0] p_score_o,
   output logic [SCORE_W-1:0] e_score_o,
   output logic               game_en_o,
   output logic               serve_o,
   output logic [1:0]         winner_o,
   output logic [2:0]         state_o
);
   localparam int CNT_W = $clog2((SERVE_TICKS > OVER_TICKS ? SERVE_TICKS : OVER_TICKS) + 1);
   localparam logic [SCORE_W-1:0] TOP = '1;
   typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, PAUSE = 3'd3, OVER = 3'd4} state_t;
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SCORE_W-1:0] p_q, p_d, e_q, e_d, p_inc, e_inc;
   logic [1:0]         win_q, win_d;
   logic               serve_q, serve_d, en_q, p_win, e_win;
   assign p_inc = p_q + 1'b1;
   assign e_inc = e_q + 1'b1;
   // reaching the all-ones score always ends the game so counters never wrap
   assign p_win = (32'(p_inc) >= MAX_SCORE && 32'(p_inc) >= 32'(e_q) + WIN_MARGIN) || p_inc == TOP;
   assign e_win = (32'(e_inc) >= MAX_SCORE && 32'(e_inc) >= 32'(p_q) + WIN_MARGIN) || e_inc == TOP;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      e_d     = e_q;
      win_d   = win_q;
      serve_d = 1'b0;
      if (game_rst_i) begin
         state_d = SERVE;
         cnt_d   = CNT_W'(SERVE_TICKS);
         p_d     = '0;
         e_d     = '0;
         win_d   = 2'b00;
      end else begin
         case (state_q)
            SERVE: if (frame_tick_i) begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  state_d = PLAY;
                  serve_d = 1'b1;
               end
            end
            PLAY: if (p_point_i) begin
               p_d     = p_inc;
               state_d = p_win ? OVER : SERVE;
               win_d   = p_win ? 2'b01 : win_q;
               cnt_d   = p_win ? CNT_W'(OVER_TICKS) : CNT_W'(SERVE_TICKS);
            end else if (e_point_i) begin
               e_d     = e_inc;
               state_d = e_win ? OVER : SERVE;
               win_d   = e_win ? 2'b10 : win_q;
               cnt_d   = e_win ? CNT_W'(OVER_TICKS) : CNT_W'(SERVE_TICKS);
            end else if (pause_i) begin
               state_d = PAUSE;
            end
            PAUSE: if (pause_i) state_d = PLAY;
            OVER: if (frame_tick_i) begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) state_d = IDLE;
            end
            default: ;
         endcase
      end
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         e_q     <= '0;
         win_q   <= 2'b00;
         serve_q <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         e_q     <= e_d;
         win_q   <= win_d;
         serve_q <= serve_d;
         en_q    <= state_q == PLAY;
      end
   end
   assign p_score_o = p_q;
   assign e_score_o = e_q;
   assign game_en_o = en_q;
   assign serve_o   = serve_q;
   assign winner_o  = win_q;
   assign state_o   = state_q;
endmodule
